// File: rtl/audio_pkg.sv
// Shared audio types and constants for the sound-effect player and mixer.
package audio_pkg;

    localparam int unsigned ADDR_W        = 14;
    localparam int unsigned DATA_W        = 16;
    localparam int unsigned VOL_W         = 3;
    localparam int unsigned SFX_JUMP_LAST = 8957;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        READ,
        LATCH
    } player_state_t;

endpackage

// File: rtl/audio_atten.sv
// Shift-based volume attenuation: arithmetic shift right by volume, all-ones volume mutes.
module audio_atten #(
    parameter int unsigned DATA_W = audio_pkg::DATA_W,
    parameter int unsigned VOL_W  = audio_pkg::VOL_W
) (
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [VOL_W-1:0]  volume,
    output logic signed [DATA_W-1:0] scaled
);

    always_comb begin
        scaled = '0;
        if (volume != '1) begin
            scaled = sample >>> volume;
        end
    end

endmodule

// File: rtl/audio_sfx_player.sv
// Playback sequencer: walks the sample RAM one word per codec request, attenuates,
// and hands samples to the codec; emits silence on the same 2-cycle cadence when idle.
module audio_sfx_player #(
    parameter int unsigned ADDR_W    = audio_pkg::ADDR_W,
    parameter int unsigned DATA_W    = audio_pkg::DATA_W,
    parameter int unsigned LAST_ADDR = audio_pkg::SFX_JUMP_LAST,
    parameter int unsigned VOL_W     = audio_pkg::VOL_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [VOL_W-1:0]  volume,
    input  logic              sample_req,
    input  logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    import audio_pkg::*;

    player_state_t state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              idle_req_q;
    logic              idle_req;
    logic              at_last;
    logic              load_sample;
    logic              set_done;
    logic              set_overrun;
    logic              clr_overrun;
    logic signed [DATA_W-1:0] scaled;

    audio_atten #(
        .DATA_W (DATA_W),
        .VOL_W  (VOL_W)
    ) u_atten (
        .sample (signed'(ram_data)),
        .volume (volume),
        .scaled (scaled)
    );

    assign at_last          = (ptr_q == ADDR_W'(LAST_ADDR));
    assign ram_read_address = ptr_q;
    assign busy             = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        load_sample = 1'b0;
        set_done    = 1'b0;
        set_overrun = 1'b0;
        clr_overrun = 1'b0;
        idle_req    = 1'b0;
        if (stop) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else if (play) begin
            state_d     = ARMED;
            ptr_d       = '0;
            clr_overrun = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idle_req = sample_req;
                end
                ARMED: begin
                    if (sample_req) begin
                        state_d = READ;
                    end
                end
                READ: begin
                    // Address has been stable since ARMED, so ram_data already holds
                    // mem[ptr]; capturing here makes the sample visible during LATCH.
                    state_d     = LATCH;
                    load_sample = 1'b1;
                    set_overrun = sample_req;
                end
                LATCH: begin
                    set_overrun = sample_req;
                    if (at_last) begin
                        ptr_d = '0;
                        if (loop_en) begin
                            state_d = ARMED;
                        end else begin
                            state_d  = IDLE;
                            set_done = 1'b1;
                        end
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q        <= '0;
            idle_req_q   <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            idle_req_q   <= idle_req;
            sample_valid <= load_sample | idle_req_q;
            done         <= set_done;
            if (load_sample) begin
                sample_out <= scaled;
            end else if (idle_req_q) begin
                sample_out <= '0;
            end
            if (clr_overrun) begin
                overrun <= 1'b0;
            end else if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sfx_player.sv
// Scoreboard bench for audio_sfx_player with a 4-word clip and a registered-read RAM model.
module tb_audio_sfx_player;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned VOL_W  = 3;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              play = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [VOL_W-1:0]  volume = '0;
    logic              sample_req = 1'b0;
    logic [DATA_W-1:0] ram_data = '0;
    logic [ADDR_W-1:0] ram_read_address;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic              overrun;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_count = 0;

    audio_sfx_player #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LAST_ADDR (3),
        .VOL_W     (VOL_W)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .play             (play),
        .stop             (stop),
        .loop_en          (loop_en),
        .volume           (volume),
        .sample_req       (sample_req),
        .ram_data         (ram_data),
        .ram_read_address (ram_read_address),
        .sample_out       (sample_out),
        .sample_valid     (sample_valid),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        ram_data <= mem[ram_read_address];
    end

    // Monitor: pops the scoreboard on every sample_valid, flags late or spurious pulses.
    always @(negedge Clk) begin
        if (done) done_count++;
        if (sample_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got sample_out=%h at cycle %0d, required no pulse",
                         sample_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sample_out !== e.data || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL sample: got %h at cycle %0d, required %h at cycle %0d",
                             sample_out, cyc, e.data, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_valid: got no pulse at cycle %0d, required %h", cyc, e.data);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic request(input logic [DATA_W-1:0] expected);
        exp_t e;
        e.data = expected;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int unsigned i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[0] = 16'h1000;
        mem[1] = 16'hF000;
        mem[2] = 16'h0123;
        mem[3] = 16'h8001;

        wait_cycles(2);
        Reset = 1'b0;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_overrun", 32'(overrun), 0);
        check("reset_valid", 32'(sample_valid), 0);
        check("reset_sample", 32'(sample_out), 0);
        check("reset_addr", 32'(ram_read_address), 0);

        // Idle silence
        request(16'h0000);
        wait_cycles(9);

        // One-shot playback, volume 0 then 2 on the last (negative) word
        pulse_play();
        check("play_busy", 32'(busy), 1);
        check("play_addr0", 32'(ram_read_address), 0);
        request(16'h1000);
        wait_cycles(9);
        check("addr1", 32'(ram_read_address), 1);
        request(16'hF000);
        wait_cycles(9);
        check("addr2", 32'(ram_read_address), 2);
        request(16'h0123);
        wait_cycles(9);
        check("addr3", 32'(ram_read_address), 3);
        volume = 3'd2;
        request(16'hE000);
        wait_cycles(9);
        check("oneshot_done_count", 32'(done_count), 1);
        check("oneshot_busy", 32'(busy), 0);
        check("oneshot_addr", 32'(ram_read_address), 0);

        // Looping playback at volume 2, then mute
        loop_en = 1'b1;
        pulse_play();
        request(16'h0400);
        wait_cycles(9);
        request(16'hFC00);
        wait_cycles(9);
        request(16'h0048);
        wait_cycles(9);
        request(16'hE000);
        wait_cycles(9);
        request(16'h0400);
        wait_cycles(9);
        volume = 3'd7;
        request(16'h0000);
        wait_cycles(9);
        check("loop_no_done", 32'(done_count), 1);
        check("loop_busy", 32'(busy), 1);

        // Back-to-back requests
        volume = 3'd0;
        request(16'h0123);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        wait_cycles(8);
        check("overrun_set", 32'(overrun), 1);
        request(16'h8001);
        wait_cycles(9);
        check("overrun_sticky", 32'(overrun), 1);
        pulse_play();
        check("overrun_cleared", 32'(overrun), 0);

        // Retrigger during READ discards the fetch
        request(16'h1000);
        wait_cycles(9);
        check("retrig_addr1", 32'(ram_read_address), 1);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        pulse_play();
        check("retrig_addr0", 32'(ram_read_address), 0);
        wait_cycles(9);
        request(16'h1000);
        wait_cycles(9);

        // stop and play together: stop wins, sample_out held
        stop = 1'b1;
        play = 1'b1;
        tick();
        stop = 1'b0;
        play = 1'b0;
        check("stop_busy", 32'(busy), 0);
        check("stop_addr", 32'(ram_read_address), 0);
        check("stop_sample_held", 32'(sample_out), 32'h1000);
        wait_cycles(5);
        check("stop_no_done", 32'(done_count), 1);

        // Reset during LATCH
        pulse_play();
        wait_cycles(3);
        request(16'h1000);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst_latch_valid", 32'(sample_valid), 0);
        check("rst_latch_sample", 32'(sample_out), 0);
        check("rst_latch_busy", 32'(busy), 0);
        wait_cycles(5);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("final_done_count", 32'(done_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
